// File: rtl/vec_acc_tree_i16.sv
// Reduces each vector of signed products with a registered adder tree, then
// accumulates ACC_BEATS reduced vectors into one result on a valid/ready output.
module vec_acc_tree_i16 #(
  parameter int PRD_WIDTH = 16,
  parameter int LENGTH    = 32,
  parameter int ACC_BEATS = 4,
  localparam int TREE_LAT  = $clog2(LENGTH),
  localparam int ACC_WIDTH = PRD_WIDTH + $clog2(LENGTH) + $clog2(ACC_BEATS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PRD_WIDTH-1:0] i_prd [LENGTH],
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam int TREE_W = PRD_WIDTH + TREE_LAT;
  localparam int CNT_W  = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  logic                        en;
  logic signed [TREE_W-1:0]    tree_sum;
  logic                        tree_valid;
  logic signed [ACC_WIDTH-1:0] tree_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] total;
  logic [CNT_W-1:0]            beat_cnt;
  logic                        last_beat;

  // A held, unconsumed result freezes the whole datapath.
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en;

  // Level 0 captures the input vector; level k holds the pairwise sums of
  // level k-1, one bit wider so no pair can overflow.
  for (genvar k = 0; k <= TREE_LAT; k++) begin : g_lvl
    localparam int W = PRD_WIDTH + k;
    localparam int N = LENGTH >> k;

    logic signed [W-1:0] data [N];
    logic                valid;

    if (k == 0) begin : g_cap
      // NOTE: the data arrays are reset as well as the valid bits, so an
      // aborted group leaves no stale operands anywhere in the tree.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid <= 1'b0;
          for (int i = 0; i < N; i++) data[i] <= '0;
        end else if (en) begin
          // NOTE: sequential state uses non-blocking assignments so every
          // level samples its predecessor's pre-edge value.
          valid <= i_valid;
          for (int i = 0; i < N; i++) data[i] <= i_prd[i];
        end
      end
    end else begin : g_add
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid <= 1'b0;
          for (int i = 0; i < N; i++) data[i] <= '0;
        end else if (en) begin
          valid <= g_lvl[k-1].valid;
          for (int i = 0; i < N; i++) begin
            data[i] <= {g_lvl[k-1].data[2*i][W-2],   g_lvl[k-1].data[2*i]}
                     + {g_lvl[k-1].data[2*i+1][W-2], g_lvl[k-1].data[2*i+1]};
          end
        end
      end
    end
  end

  assign tree_sum   = g_lvl[TREE_LAT].data[0];
  assign tree_valid = g_lvl[TREE_LAT].valid;
  assign last_beat  = (beat_cnt == CNT_W'(ACC_BEATS - 1));

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    tree_ext = ACC_WIDTH'(tree_sum);
    total    = (beat_cnt == '0) ? tree_ext : acc + tree_ext;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      o_sum    <= '0;
      o_valid  <= 1'b0;
    end else if (en) begin
      // en here means any held result is being consumed on this edge.
      o_valid <= 1'b0;
      if (tree_valid) begin
        acc <= total;
        if (last_beat) begin
          o_sum    <= total;
          o_valid  <= 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_acc_tree_i16.sv
// Directed bench for vec_acc_tree_i16: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_vec_acc_tree_i16;

  localparam int PRD_WIDTH = 16;
  localparam int LENGTH    = 32;
  localparam int ACC_BEATS = 4;
  localparam int TREE_LAT  = 5;
  localparam int ACC_WIDTH = 23;

  localparam int K_ONES = 0;
  localparam int K_NEG  = 1;
  localparam int K_IDX  = 2;
  localparam int K_MIN  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [PRD_WIDTH-1:0] prd [LENGTH];
  logic                 prd_valid;
  logic                 prd_ready;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sum_valid;
  logic                 sum_ready;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  typedef struct {
    longint value;
    int     due;
  } pend_t;

  pend_t  pend_q[$];
  longint out_log[$];
  bit     m_valid;
  longint m_sum;
  longint grp_sum;
  int     grp_n;
  int     en_edges;
  bit     en_m;
  longint vec_total;
  int     last_accept_edge;
  int     rise_edge;
  bit     prev_valid;

  vec_acc_tree_i16 #(
    .PRD_WIDTH(PRD_WIDTH),
    .LENGTH   (LENGTH),
    .ACC_BEATS(ACC_BEATS)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_prd  (prd),
    .i_valid(prd_valid),
    .o_ready(prd_ready),
    .o_sum  (sum),
    .o_valid(sum_valid),
    .i_ready(sum_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sum_s();
    return longint'($signed(sum));
  endfunction

  // Reference model: each accepted vector contributes its element sum; every
  // ACC_BEATS accepts form one result that appears TREE_LAT+1 enabled edges
  // after the final accept and is held until consumed.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      m_valid    = 1'b0;
      m_sum      = 0;
      grp_sum    = 0;
      grp_n      = 0;
      prev_valid = 1'b0;
      pend_q.delete();
    end else begin
      en_m = !(m_valid && !sum_ready);
      check("o_ready", prd_ready, en_m);
      check("o_valid", sum_valid, m_valid);
      if (m_valid) check("o_sum", sum_s(), m_sum);
      if (sum_valid && !prev_valid) rise_edge = edge_no;
      prev_valid = sum_valid;
      if (sum_valid && sum_ready) out_log.push_back(sum_s());
      if (en_m) begin
        en_edges++;
        if (m_valid && sum_ready) m_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == en_edges) begin
          m_valid = 1'b1;
          m_sum   = pend_q[0].value;
          void'(pend_q.pop_front());
        end
        if (prd_valid) begin
          last_accept_edge = edge_no + 1;
          vec_total = 0;
          for (int j = 0; j < LENGTH; j++) vec_total += longint'($signed(prd[j]));
          grp_sum += vec_total;
          grp_n++;
          if (grp_n == ACC_BEATS) begin
            pend_q.push_back('{value: grp_sum, due: en_edges + TREE_LAT + 1});
            grp_sum = 0;
            grp_n   = 0;
          end
        end
      end
    end
  end

  task automatic set_vec(input int kind);
    for (int j = 0; j < LENGTH; j++) begin
      case (kind)
        K_ONES:  prd[j] = 16'h0001;
        K_NEG:   prd[j] = 16'hFFFF;
        K_IDX:   prd[j] = 16'(j);
        default: prd[j] = 16'h8000;
      endcase
    end
  endtask

  // Presents one beat from a falling edge and retries until it is accepted.
  task automatic send_beat(input int kind);
    bit ok = 1'b0;
    int tries = 0;
    @(negedge clk);
    set_vec(kind);
    prd_valid = 1'b1;
    while (!ok) begin
      #1;
      ok = prd_ready;
      @(posedge clk);
      if (!ok) begin
        tries++;
        if (tries > 200) begin
          check("accept_timeout", tries, 0);
          ok = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      prd_valid = 1'b0;
    end
  endtask

  task automatic send_group(input int kind, input int max_gap);
    for (int b = 0; b < ACC_BEATS; b++) begin
      send_beat(kind);
      if (max_gap > 0) idle($urandom_range(1, max_gap));
    end
  endtask

  task automatic wait_outputs(input int target, input int budget);
    int t = 0;
    idle(1);
    while (out_log.size() < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    idle(12);
    check("output_count", out_log.size(), target);
  endtask

  task automatic check_out(input string name, input int idx, input longint exp);
    if (idx < out_log.size()) check(name, out_log[idx], exp);
    else check(name, out_log.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    prd_valid = 1'b0;
    sum_ready = 1'b1;
    set_vec(K_ONES);
    rst_n = 1'b0;
    #3;
    check("reset_o_valid", sum_valid, 0);
    check("reset_o_sum", sum_s(), 0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", prd_ready, 1);

    // Back-to-back ones: one result, TREE_LAT+1 edges after the last accept.
    base = out_log.size();
    send_group(K_ONES, 0);
    wait_outputs(base + 1, 40);
    check("latency", rise_edge - last_accept_edge, 6);
    check_out("ones_sum", base, 128);

    // All -1, then element index, back to back.
    base = out_log.size();
    send_group(K_NEG, 0);
    send_group(K_IDX, 0);
    wait_outputs(base + 2, 60);
    check_out("neg_sum", base, -128);
    check_out("index_sum", base + 1, 1984);

    // Most negative products: exact result, no wrap.
    base = out_log.size();
    send_group(K_MIN, 0);
    wait_outputs(base + 1, 40);
    check_out("min_sum", base, -4194304);

    // Result stalled for 5 cycles while inputs keep arriving.
    base = out_log.size();
    fork
      begin
        send_group(K_ONES, 0);
        send_group(K_IDX, 0);
        send_group(K_NEG, 0);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!sum_valid && t < 60) begin
          @(negedge clk);
          t++;
        end
        sum_ready = 1'b0;
        repeat (5) begin
          #1;
          check("hold_o_ready", prd_ready, 0);
          check("hold_o_valid", sum_valid, 1);
          check("hold_o_sum", sum_s(), 128);
          @(negedge clk);
        end
        sum_ready = 1'b1;
      end
    join
    wait_outputs(base + 3, 80);
    check_out("bp_first", base, 128);
    check_out("bp_second", base + 1, 1984);
    check_out("bp_third", base + 2, -128);

    // Random bubbles between beats give the same single result.
    base = out_log.size();
    send_group(K_ONES, 3);
    wait_outputs(base + 1, 40);
    check_out("bubble_sum", base, 128);

    // Reset while a result is held and two further beats are in flight.
    sum_ready = 1'b0;
    send_group(K_ONES, 0);
    send_beat(K_IDX);
    send_beat(K_IDX);
    idle(1);
    t = 0;
    while (!sum_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("held_before_reset", sum_s(), 128);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_o_valid", sum_valid, 0);
    check("async_reset_o_sum", sum_s(), 0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    sum_ready = 1'b1;
    base = out_log.size();
    send_group(K_ONES, 0);
    wait_outputs(base + 1, 40);
    check_out("after_reset_sum", base, 128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
